// File: rtl/spi_stream_target.sv
// spi_stream_target: SPI mode-0 read responder (opcode + 24-bit address, then a
// 32-bit word stream fetched from a memory read port with one-word prefetch).
module spi_stream_target #(
    parameter logic [7:0] OPCODE      = 8'h03,
    parameter int         W_ADDR      = 22,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs_n,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_req,
    output logic [W_ADDR-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic              opcode_err
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic [4:0]             bit_ctr_q, data_ctr_q;
    logic [22:0]            sh_q;
    logic [30:0]            sreg_q;
    logic [W_ADDR-1:0]      word_addr_q, mem_addr_q;
    logic [31:0]            buf_q;
    logic                   buf_valid_q, stale_q, want_q, mem_req_q;
    logic                   miso_q, oe_q, underrun_q, oerr_q;

    logic              cs_s, sck_s, mosi_s, rise, fall, ack, can_issue, avail;
    logic [31:0]       load_w, load_d;
    logic [W_ADDR-1:0] word_addr_d;

    always_comb begin
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        rise        = sck_s & ~sck_prev_q;
        fall        = ~sck_s & sck_prev_q;
        ack         = mem_req_q & mem_ack;
        can_issue   = ~mem_req_q | mem_ack;
        // data acked in the very cycle of a load point is used directly
        avail       = buf_valid_q | (ack & ~stale_q);
        load_w      = buf_valid_q ? buf_q : mem_rdata;
        load_d      = avail ? {load_w[7:0], load_w[15:8], load_w[23:16], load_w[31:24]} : 32'd0;
        word_addr_d = word_addr_q + W_ADDR'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            bit_ctr_q   <= '0;
            data_ctr_q  <= '0;
            sh_q        <= '0;
            sreg_q      <= '0;
            word_addr_q <= '0;
            mem_addr_q  <= '0;
            buf_q       <= '0;
            buf_valid_q <= 1'b0;
            stale_q     <= 1'b0;
            want_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            underrun_q  <= 1'b0;
            oerr_q      <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_prev_q  <= sck_s;
            oerr_q      <= 1'b0;
            if (underrun_clr)
                underrun_q <= 1'b0;
            if (ack) begin
                mem_req_q <= 1'b0;
                stale_q   <= 1'b0;
                if (!stale_q && !cs_s) begin
                    buf_q       <= mem_rdata;
                    buf_valid_q <= 1'b1;
                end
            end
            // a fetch deferred behind an abandoned request goes out once that one completes
            if (want_q && can_issue) begin
                mem_req_q  <= 1'b1;
                mem_addr_q <= word_addr_q;
                want_q     <= 1'b0;
            end
            if (cs_s) begin
                state_q     <= IDLE;
                miso_q      <= 1'b0;
                oe_q        <= 1'b0;
                buf_valid_q <= 1'b0;
                want_q      <= 1'b0;
                if (mem_req_q && !mem_ack)
                    stale_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q   <= CMD;
                        bit_ctr_q <= '0;
                        oe_q      <= 1'b1;
                        miso_q    <= 1'b0;
                    end
                    CMD: if (rise) begin
                        sh_q      <= {sh_q[21:0], mosi_s};
                        bit_ctr_q <= bit_ctr_q + 5'd1;
                        if (bit_ctr_q == 5'd7) begin
                            bit_ctr_q <= '0;
                            if ({sh_q[6:0], mosi_s} == OPCODE)
                                state_q <= ADDR;
                            else begin
                                state_q <= IGNORE;
                                oerr_q  <= 1'b1;
                            end
                        end
                    end
                    ADDR: if (rise) begin
                        sh_q      <= {sh_q[21:0], mosi_s};
                        bit_ctr_q <= bit_ctr_q + 5'd1;
                        if (bit_ctr_q == 5'd23) begin
                            state_q     <= DATA;
                            data_ctr_q  <= '0;
                            word_addr_q <= sh_q[W_ADDR:1];
                            if (can_issue) begin
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= sh_q[W_ADDR:1];
                            end else
                                want_q <= 1'b1;
                        end
                    end
                    DATA: if (fall) begin
                        data_ctr_q <= data_ctr_q + 5'd1;
                        if (data_ctr_q == 5'd0) begin
                            sreg_q      <= load_d[30:0];
                            miso_q      <= load_d[31];
                            buf_valid_q <= 1'b0;
                            word_addr_q <= word_addr_d;
                            if (!avail)
                                underrun_q <= 1'b1;
                            // a still-pending fetch is left to fill the buffer for the next word
                            if (can_issue) begin
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= word_addr_d;
                            end
                        end else begin
                            sreg_q <= {sreg_q[29:0], 1'b0};
                            miso_q <= sreg_q[30];
                        end
                    end
                    IGNORE: miso_q <= 1'b0;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = ~cs_s;
    assign underrun    = underrun_q;
    assign opcode_err  = oerr_q;
endmodule

// File: tb/tb_spi_stream_target.sv
// tb_spi_stream_target: drives SPI read transactions against a latency-controlled
// memory model; expected MISO bytes and fetch addresses are queued and popped on arrival.
module tb_spi_stream_target;
    localparam int H = 8;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        spi_cs_n = 1'b1, spi_sck = 1'b0, spi_mosi = 1'b0;
    logic        mem_ack = 1'b0, underrun_clr = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        spi_miso, spi_miso_oe, mem_req, busy, underrun, opcode_err;
    logic [21:0] mem_addr;

    int          n_tests = 0, n_fail = 0;
    logic [7:0]  exp_b[$];
    logic [21:0] exp_a[$];
    logic [31:0] mem[int];
    int          lat = 1, cur_lat = 0, cnt = 0, req_cyc = 0, oerr_cnt = 0;
    logic        clr_pulse = 1'b0, clr_hold = 1'b0, clr_seen = 1'b0;

    always #5 clk = ~clk;

    spi_stream_target dut (
        .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .underrun(underrun),
        .underrun_clr(underrun_clr), .opcode_err(opcode_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [21:0] a);
        return mem.exists(int'(a)) ? mem[int'(a)] : (32'hA500_0000 ^ {10'd0, a});
    endfunction

    task automatic push_word(input logic [31:0] w);
        exp_b.push_back(w[7:0]);
        exp_b.push_back(w[15:8]);
        exp_b.push_back(w[23:16]);
        exp_b.push_back(w[31:24]);
    endtask

    // memory responder, monitors and underrun_clr driver
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (opcode_err)
            oerr_cnt++;
        if (mem_req) begin
            req_cyc++;
            if (cnt == 0)
                cur_lat = lat;
            cnt++;
            if (cnt > cur_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = rd(mem_addr);
                cnt       = 0;
                if (exp_a.size() == 0)
                    chk("mem_addr_unexpected", {10'd0, mem_addr}, 32'hFFFF_FFFF);
                else
                    chk("mem_addr", {10'd0, mem_addr}, {10'd0, exp_a.pop_front()});
            end
        end else
            cnt = 0;
        if (!clr_hold)
            clr_seen = 1'b0;
        else if (underrun)
            clr_seen = 1'b1;
        underrun_clr = clr_pulse | (clr_hold & ~clr_seen);
    end

    task automatic sck_bit(input logic mo, input logic end_cs, output logic mi);
        spi_mosi = mo;
        repeat (H) @(negedge clk);
        mi = spi_miso;
        spi_sck = 1'b1;
        repeat (H) @(negedge clk);
        spi_sck = 1'b0;
        if (end_cs)
            spi_cs_n = 1'b1;
    endtask

    task automatic xfer_start(input logic [7:0] op, input logic [23:0] a);
        logic mi;
        spi_cs_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 7; i >= 0; i--)
            sck_bit(op[i], 1'b0, mi);
        for (int i = 23; i >= 0; i--)
            sck_bit(a[i], 1'b0, mi);
    endtask

    task automatic xfer_data(input int nbits, input logic stop);
        logic       mi;
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < nbits; i++) begin
            sck_bit(1'b0, stop && (i == nbits - 1), mi);
            b = {b[6:0], mi};
            if (i % 8 == 7) begin
                if (exp_b.size() == 0)
                    chk("miso_unexpected", {24'd0, b}, 32'h1FF);
                else
                    chk("miso_byte", {24'd0, b}, {24'd0, exp_b.pop_front()});
            end
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int          c0, r0;
        logic [31:0] w;
        repeat (3) @(negedge clk);
        chk("rst_outs", {spi_miso, spi_miso_oe, mem_req, busy, underrun, opcode_err, mem_addr}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // plain two-word read
        mem[32'h40] = 32'h4433_2211;
        mem[32'h41] = 32'h8877_6655;
        push_word(32'h4433_2211);
        push_word(32'h8877_6655);
        exp_a.push_back(22'h40);
        exp_a.push_back(22'h41);
        exp_a.push_back(22'h42);
        xfer_start(8'h03, 24'h000100);
        chk("t1_busy_oe", {30'd0, busy, spi_miso_oe}, 32'd3);
        xfer_data(64, 1'b1);
        chk("t1_end_busy_oe", {30'd0, busy, spi_miso_oe}, 32'd0);
        chk("t1_underrun", {31'd0, underrun}, 32'd0);
        chk("t1_addrs_left", exp_a.size(), 32'd0);

        // wrong opcode
        c0 = oerr_cnt;
        r0 = req_cyc;
        repeat (4) exp_b.push_back(8'h00);
        xfer_start(8'h0B, 24'h000100);
        xfer_data(32, 1'b1);
        chk("t2_opcode_err_pulses", oerr_cnt - c0, 32'd1);
        chk("t2_req_cycles", req_cyc - r0, 32'd0);

        // late first fetch -> underrun, zero word, late data serves the next word
        lat = 12;
        repeat (4) exp_b.push_back(8'h00);
        push_word(rd(22'h80));
        exp_a.push_back(22'h80);
        exp_a.push_back(22'h82);
        xfer_start(8'h03, 24'h000200);
        lat = 1;
        xfer_data(64, 1'b1);
        chk("t3_underrun_set", {31'd0, underrun}, 32'd1);
        @(posedge clk); #1 clr_pulse = 1'b1;
        @(posedge clk); #1 clr_pulse = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_underrun_clr", {31'd0, underrun}, 32'd0);
        @(posedge clk); #1 clr_hold = 1'b1;
        lat = 12;
        repeat (4) exp_b.push_back(8'h00);
        exp_a.push_back(22'h80);
        xfer_start(8'h03, 24'h000200);
        lat = 1;
        xfer_data(32, 1'b1);
        chk("t3_set_beats_clr", {31'd0, underrun}, 32'd1);
        @(posedge clk); #1 clr_hold = 1'b0;

        // abort with a fetch pending, then a clean transaction
        w = rd(22'h0C0);
        exp_b.push_back(w[7:0]);
        exp_a.push_back(22'h0C0);
        exp_a.push_back(22'h0C1);
        xfer_start(8'h03, 24'h000300);
        lat = 400;
        xfer_data(13, 1'b1);
        chk("t4_busy_oe", {30'd0, busy, spi_miso_oe}, 32'd0);
        chk("t4_req_held", {31'd0, mem_req}, 32'd1);
        for (int i = 0; i < 600 && mem_req; i++)
            @(negedge clk);
        chk("t4_req_released", {31'd0, mem_req}, 32'd0);
        lat = 1;
        push_word(rd(22'h2));
        exp_a.push_back(22'h2);
        exp_a.push_back(22'h3);
        xfer_start(8'h03, 24'h000008);
        xfer_data(32, 1'b1);
        chk("t4_addrs_left", exp_a.size(), 32'd0);

        // word address wrap
        push_word(rd(22'h3FFFFF));
        push_word(rd(22'h0));
        exp_a.push_back(22'h3FFFFF);
        exp_a.push_back(22'h0);
        exp_a.push_back(22'h1);
        xfer_start(8'h03, 24'hFFFFFC);
        xfer_data(64, 1'b1);
        chk("t5_addrs_left", exp_a.size(), 32'd0);

        // asynchronous reset in the middle of DATA
        lat = 12;
        exp_b.push_back(8'h00);
        exp_a.push_back(22'h100);
        xfer_start(8'h03, 24'h000400);
        lat = 1;
        xfer_data(10, 1'b0);
        chk("t6_pre_busy_oe_ur", {29'd0, busy, spi_miso_oe, underrun}, 32'd7);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t6_rst_outs", {spi_miso, spi_miso_oe, mem_req, busy, underrun, opcode_err, mem_addr}, 32'd0);
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push_word(rd(22'h101));
        exp_a.push_back(22'h101);
        exp_a.push_back(22'h102);
        xfer_start(8'h03, 24'h000404);
        xfer_data(32, 1'b1);
        chk("t6_underrun_after", {31'd0, underrun}, 32'd0);

        chk("queues_empty", exp_a.size() + exp_b.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
